cu_command_arbiter_rr: RTL and testbench
========================================

// Module: cu_command_arbiter_rr
// PURPOSE
//  Round-robin arbiter sharing one CAPI command buffer (read or write) among NUM_REQUESTS
//  compute-unit command sources. Per-requester 1-entry holding register, ready backpressure,
//  stalls on buffer almost-full. Sits between cu_control read/write engines and the AFU command buffer.
// PARAMETERS
//  NUM_REQUESTS  2                     number of requesters; legal range >= 1
//  PTR_BITS      $clog2(NUM_REQUESTS)  derived (min 1); width of priority pointer
// PORTS
//  clock                     in   1                            clock, all state on posedge
//  rstn                      in   1                            async active-low reset
//  enabled_in                in   1                            global enable
//  command_in[NUM_REQUESTS]  in   CommandBufferLine each       requester commands; .valid = offer
//  command_buffer_status_in  in   BufferStatus                 shared buffer status; only .alfull used
//  command_ready_out         out  NUM_REQUESTS                 requester i may offer this cycle
//  command_out               out  CommandBufferLine            registered issued command
//  grant_out                 out  NUM_REQUESTS                 registered one-hot of requester issued
//  issued_count_out          out  64                           total commands issued
// BEHAVIOUR
//  Reset (async, rstn=0): pending[]=0, held[]=0, ptr=NUM_REQUESTS-1 (requester 0 wins first),
//   command_out=0, grant_out=0, issued_count_out=0. Reset mid-operation discards held commands.
//  Capture: command_in[i] accepted at edge when enabled_in && command_in[i].valid &&
//   command_ready_out[i]; held[i]<=command_in[i], pending[i]<=1.
//   Offer while ready low = protocol violation: ignored, flagged by bench assertion.
//  Ready (combinational): command_ready_out[i] = enabled_in && (~pending[i] || grant_now[i]).
//   Back-to-back reload in the same cycle as grant is allowed, so one requester can sustain 1 cmd/cycle.
//  Grant condition: go = enabled_in && ~command_buffer_status_in.alfull && |pending.
//   Select winner w = first set pending[] scanning ptr+1, ptr+2, ... modulo NUM_REQUESTS.
//   grant_now = onehot(w) when go, else 0.
//  Issue edge (go=1): command_out<=held[w] with .valid=1, grant_out<=onehot(w), ptr<=w,
//   pending[w]<=0 unless reloaded the same cycle, issued_count_out<=issued_count_out+1.
//  No-issue edge (go=0): command_out<=0, grant_out<=0; ptr, pending[], held[] unchanged.
//  Latency: offer at edge t -> pending after t -> earliest command_out valid after edge t+1.
//   Issue rate max 1/cycle.
//  Fairness: requester continuously pending is served within NUM_REQUESTS issue slots. No starvation.
//  alfull=1: no grant that cycle; capture continues until holding registers are full, then ready=0.
//  enabled_in=0: no capture, no grant, ready=0, command_out/grant_out cleared next edge;
//   pending state retained and resumes when enabled_in returns.
//  issued_count_out wraps 2^64-1 -> 0. Arithmetic is unsigned.
//  NUM_REQUESTS=1: ptr is a constant 0 and the block degenerates to a registered single-slot pass-through.
// STRUCTURE
//  CU_PKG additions: ARBITER_NUM_REQUESTS constant, typedef ArbiterGrantVector
//   (logic [0:NUM_REQUESTS-1]).
//  Reuse CommandBufferLine / BufferStatus from AFU_PKG unchanged.
//  One sub-module: cu_round_robin_priority_select. Combinational; inputs pending mask + ptr;
//   outputs onehot winner + encoded index. Double-mask (mask above ptr, then wrap) implementation.
// TESTING
//  1. Reset, N=2, single offer req0 at cycle 1 -> command_out.valid at cycle 3, grant_out=2'b10,
//     issued_count_out=1.
//  2. Both requesters offer every cycle, alfull=0, 20 cycles -> grants strictly alternate 10,01,...;
//     issued count=19; no gaps after first issue.
//  3. alfull=1 for 5 cycles with both pending -> command_out.valid=0, ready=0 after capture;
//     alfull drops -> req0 issues first.
//  4. N=4, req2 and req3 pending, ptr=2 -> req3 issues then req2; req1 offered mid-way
//     is served before req2 repeats.
//  5. Assert rstn low while 2 commands pending -> all outputs 0 asynchronously;
//     after release no stale command issues.
//  6. enabled_in low 3 cycles with req1 pending -> no issue, ready=0;
//     re-enable -> req1 issues next edge with original payload.

Source files
------------

// File: rtl/cu_command_arbiter_rr_pkg.sv
// Shared types for the compute-unit command arbiter: command buffer line, buffer
// status and the arbiter grant vector.
package cu_command_arbiter_rr_pkg;

  localparam int ARBITER_NUM_REQUESTS = 2;

  typedef logic [0:ARBITER_NUM_REQUESTS-1] ArbiterGrantVector;

  typedef struct packed {
    logic        valid;
    logic [7:0]  command;
    logic [63:0] address;
    logic [11:0] size;
    logic [7:0]  cu_id;
    logic [7:0]  tag;
  } CommandBufferLine;

  typedef struct packed {
    logic valid;
    logic empty;
    logic alfull;
    logic full;
  } BufferStatus;

  // Priority pointer width; a single requester still needs one bit.
  function automatic int arbiter_ptr_bits(input int num_requests);
    return (num_requests > 1) ? $clog2(num_requests) : 1;
  endfunction

endpackage

// File: rtl/cu_round_robin_priority_select.sv
// Combinational round-robin winner select: first pending requester strictly after ptr,
// wrapping to the lowest pending index when nothing lies above the pointer.
module cu_round_robin_priority_select #(
  parameter int NUM_REQUESTS = 2,
  parameter int PTR_BITS     = 1
) (
  input  logic [0:NUM_REQUESTS-1] pending,
  input  logic [PTR_BITS-1:0]     ptr,
  output logic [0:NUM_REQUESTS-1] grant_onehot,
  output logic [PTR_BITS-1:0]     grant_index
);

  logic [0:NUM_REQUESTS-1] upper_mask;
  logic [0:NUM_REQUESTS-1] masked;
  logic [0:NUM_REQUESTS-1] pick_src;
  logic                    found;

  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < NUM_REQUESTS; i++) begin
      upper_mask[i] = (i > int'(ptr));
    end
    masked   = pending & upper_mask;
    // Nothing above the pointer: wrap and take the lowest pending index.
    pick_src = (|masked) ? masked : pending;

    grant_onehot = '0;
    grant_index  = '0;
    found        = 1'b0;
    for (int i = 0; i < NUM_REQUESTS; i++) begin
      if (pick_src[i] && !found) begin
        grant_onehot[i] = 1'b1;
        grant_index     = PTR_BITS'(i);
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cu_command_arbiter_rr.sv
// Round-robin arbiter sharing one command buffer among NUM_REQUESTS command sources,
// each with a one-entry holding register; stalls while the buffer is almost full.
module cu_command_arbiter_rr
  import cu_command_arbiter_rr_pkg::*;
#(
  parameter int NUM_REQUESTS = ARBITER_NUM_REQUESTS
) (
  input  logic                    clock,
  input  logic                    rstn,
  input  logic                    enabled_in,
  input  CommandBufferLine        command_in [NUM_REQUESTS],
  input  BufferStatus             command_buffer_status_in,
  output logic [0:NUM_REQUESTS-1] command_ready_out,
  output CommandBufferLine        command_out,
  output logic [0:NUM_REQUESTS-1] grant_out,
  output logic [63:0]             issued_count_out
);

  localparam int PTR_BITS = arbiter_ptr_bits(NUM_REQUESTS);

  logic [0:NUM_REQUESTS-1] pending;
  CommandBufferLine        held [NUM_REQUESTS];
  logic [PTR_BITS-1:0]     ptr;

  logic [0:NUM_REQUESTS-1] sel_onehot;
  logic [PTR_BITS-1:0]     sel_index;
  logic [0:NUM_REQUESTS-1] grant_now;
  logic [0:NUM_REQUESTS-1] accept;
  logic                    go;
  CommandBufferLine        issue_line;
  logic                    unused_status;

  assign unused_status = ^{command_buffer_status_in.valid, command_buffer_status_in.empty,
                           command_buffer_status_in.full};

  cu_round_robin_priority_select #(
    .NUM_REQUESTS (NUM_REQUESTS),
    .PTR_BITS     (PTR_BITS)
  ) u_select (
    .pending      (pending),
    .ptr          (ptr),
    .grant_onehot (sel_onehot),
    .grant_index  (sel_index)
  );

  // Handshake: requester i transfers command_in[i] on a rising edge where
  // command_in[i].valid && command_ready_out[i] (and enabled_in). Ready does not depend
  // on valid; a slot being granted this cycle is ready again, so reloads are back-to-back.
  always_comb begin
    go        = enabled_in && !command_buffer_status_in.alfull && (|pending);
    grant_now = go ? sel_onehot : '0;
    for (int i = 0; i < NUM_REQUESTS; i++) begin
      command_ready_out[i] = enabled_in && (!pending[i] || grant_now[i]);
      accept[i]            = enabled_in && command_in[i].valid && command_ready_out[i];
    end
    issue_line       = held[sel_index];
    issue_line.valid = 1'b1;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      pending          <= '0;
      ptr              <= PTR_BITS'(NUM_REQUESTS - 1);
      command_out      <= '0;
      grant_out        <= '0;
      issued_count_out <= '0;
      for (int i = 0; i < NUM_REQUESTS; i++) begin
        held[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQUESTS; i++) begin
        if (accept[i]) begin
          held[i] <= command_in[i];
        end
        pending[i] <= accept[i] || (pending[i] && !grant_now[i]);
      end
      if (go) begin
        command_out      <= issue_line;
        grant_out        <= grant_now;
        ptr              <= sel_index;
        issued_count_out <= issued_count_out + 64'd1;
      end else begin
        command_out <= '0;
        grant_out   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cu_command_arbiter_rr.sv
// Bench for cu_command_arbiter_rr: N=2 and N=4 instances driven side by side against a
// queue-free behavioural model of round-robin service; directed scenarios then random traffic.
module tb_cu_command_arbiter_rr;
  import cu_command_arbiter_rr_pkg::*;

  logic             clock = 1'b0;
  logic             rstn  = 1'b0;
  logic             enabled = 1'b0;
  BufferStatus      status = '0;

  CommandBufferLine cmd_v [2][4];
  CommandBufferLine cmd2 [2];
  CommandBufferLine cmd4 [4];
  logic [0:1]       ready2, grant2;
  logic [0:3]       ready4, grant4;
  CommandBufferLine out2, out4;
  logic [63:0]      count2, count4;
  logic [3:0]       rdy_v [2];
  logic [3:0]       gnt_v [2];

  // behavioural model state
  bit               m_pending [2][4];
  CommandBufferLine m_held [2][4];
  int               m_last [2];
  CommandBufferLine m_out [2];
  logic [3:0]       m_grant [2];
  logic [63:0]      m_count [2];

  int n_checks = 0;
  int n_fail   = 0;
  CommandBufferLine saved;

  always #5 clock = ~clock;

  cu_command_arbiter_rr #(.NUM_REQUESTS(2)) u_dut2 (
    .clock                    (clock),
    .rstn                     (rstn),
    .enabled_in               (enabled),
    .command_in               (cmd2),
    .command_buffer_status_in (status),
    .command_ready_out        (ready2),
    .command_out              (out2),
    .grant_out                (grant2),
    .issued_count_out         (count2)
  );

  cu_command_arbiter_rr #(.NUM_REQUESTS(4)) u_dut4 (
    .clock                    (clock),
    .rstn                     (rstn),
    .enabled_in               (enabled),
    .command_in               (cmd4),
    .command_buffer_status_in (status),
    .command_ready_out        (ready4),
    .command_out              (out4),
    .grant_out                (grant4),
    .issued_count_out         (count4)
  );

  always_comb begin
    rdy_v[0] = '0;
    gnt_v[0] = '0;
    rdy_v[1] = '0;
    gnt_v[1] = '0;
    for (int i = 0; i < 2; i++) begin
      cmd2[i]     = cmd_v[0][i];
      rdy_v[0][i] = ready2[i];
      gnt_v[0][i] = grant2[i];
    end
    for (int i = 0; i < 4; i++) begin
      cmd4[i]     = cmd_v[1][i];
      rdy_v[1][i] = ready4[i];
      gnt_v[1][i] = grant4[i];
    end
  end

  function automatic int nreq(input int s);
    return (s == 0) ? 2 : 4;
  endfunction

  function automatic CommandBufferLine rand_line();
    CommandBufferLine l;
    l.valid   = 1'b0;
    l.command = 8'($urandom);
    l.address = {$urandom, $urandom};
    l.size    = 12'($urandom_range(0, 4095));
    l.cu_id   = 8'($urandom);
    l.tag     = 8'($urandom);
    return l;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) begin
        m_pending[s][i] = 1'b0;
        m_held[s][i]    = '0;
      end
      m_last[s]  = nreq(s) - 1;
      m_out[s]   = '0;
      m_grant[s] = '0;
      m_count[s] = '0;
    end
  endtask

  task automatic clear_inputs();
    enabled = 1'b0;
    status  = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) cmd_v[s][i] = '0;
    end
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    rstn = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive at negedge, compare just after, advance the model across the edge.
  task automatic step(input logic [3:0] want0, input logic [3:0] want1, input logic en,
                      input logic af);
    int               win [2];
    logic [3:0]       exp_rdy [2];
    logic [3:0]       acc [2];
    logic [3:0]       want;
    CommandBufferLine issued;
    @(negedge clock);
    enabled = en;
    status  = '0;
    status.alfull = af;
    for (int s = 0; s < 2; s++) begin
      want   = (s == 0) ? want0 : want1;
      win[s] = -1;
      if (en && !af) begin
        for (int k = 1; k <= nreq(s); k++) begin
          int j;
          j = (m_last[s] + k) % nreq(s);
          if (m_pending[s][j] && win[s] < 0) win[s] = j;
        end
      end
      exp_rdy[s] = '0;
      acc[s]     = '0;
      for (int i = 0; i < nreq(s); i++) begin
        exp_rdy[s][i] = en && (!m_pending[s][i] || (win[s] == i));
        cmd_v[s][i]   = rand_line();
        if (want[i] && exp_rdy[s][i]) begin
          cmd_v[s][i].valid = 1'b1;
          acc[s][i]         = 1'b1;
        end
      end
    end
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("ready[%0d]", s), 128'(rdy_v[s]), 128'(exp_rdy[s]));
      check($sformatf("command_out[%0d]", s), 128'((s == 0) ? out2 : out4), 128'(m_out[s]));
      check($sformatf("grant_out[%0d]", s), 128'(gnt_v[s]), 128'(m_grant[s]));
      check($sformatf("issued_count[%0d]", s), 128'((s == 0) ? count2 : count4),
            128'(m_count[s]));
      for (int i = 0; i < nreq(s); i++) begin
        if (acc[s][i]) check($sformatf("offer_ready[%0d][%0d]", s, i), 128'(rdy_v[s][i]), 128'(1));
      end
    end
    for (int s = 0; s < 2; s++) begin
      if (win[s] >= 0) begin
        issued       = m_held[s][win[s]];
        issued.valid = 1'b1;
        m_out[s]     = issued;
        m_grant[s]   = 4'b0001 << win[s];
        m_last[s]    = win[s];
        m_count[s]   = m_count[s] + 64'd1;
        m_pending[s][win[s]] = 1'b0;
      end else begin
        m_out[s]   = '0;
        m_grant[s] = '0;
      end
      for (int i = 0; i < nreq(s); i++) begin
        if (acc[s][i]) begin
          m_pending[s][i] = 1'b1;
          m_held[s][i]    = cmd_v[s][i];
        end
      end
    end
    @(posedge clock);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) cmd_v[s][i] = '0;
    end
    apply_reset();

    // reset state
    check("rst_command_out2", 128'(out2), 128'(0));
    check("rst_grant2", 128'(grant2), 128'(0));
    check("rst_count2", 128'(count2), 128'(0));
    check("rst_grant4", 128'(grant4), 128'(0));

    // single offer from requester 0: issues on the second edge
    step(4'b0001, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    #1;
    check("s1_valid", 128'(out2.valid), 128'(1));
    check("s1_grant", 128'(grant2), 128'(2'b10));
    check("s1_count", 128'(count2), 128'(1));
    step(4'b0000, 4'b0000, 1'b1, 1'b0);

    // both requesters offering every cycle: strict alternation
    for (int c = 0; c < 20; c++) step(4'b0011, 4'b1111, 1'b1, 1'b0);

    // almost-full stall with both requesters pending, then release
    for (int c = 0; c < 5; c++) step(4'b0011, 4'b1111, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) step(4'b0000, 4'b0000, 1'b1, 1'b0);

    // N=4 pointer walk from a fresh reset
    apply_reset();
    step(4'b0000, 4'b0100, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b1100, 1'b1, 1'b0);
    step(4'b0000, 4'b0010, 1'b1, 1'b0);
    #1 check("s4_req3", 128'(grant4), 128'(4'b0001));
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    #1 check("s4_req1", 128'(grant4), 128'(4'b0100));
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    #1 check("s4_req2", 128'(grant4), 128'(4'b0010));

    // asynchronous reset with commands pending
    step(4'b0011, 4'b1111, 1'b1, 1'b1);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    @(negedge clock);
    #2 rstn = 1'b0;
    clear_inputs();
    #1;
    check("arst_out2", 128'(out2), 128'(0));
    check("arst_grant2", 128'(grant2), 128'(0));
    check("arst_count2", 128'(count2), 128'(0));
    check("arst_out4", 128'(out4), 128'(0));
    check("arst_grant4", 128'(grant4), 128'(0));
    check("arst_count4", 128'(count4), 128'(0));
    model_reset();
    @(posedge clock);
    @(negedge clock);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) step(4'b0000, 4'b0000, 1'b1, 1'b0);
    #1 check("arst_no_stale", 128'(count2), 128'(0));

    // disable with requester 1 pending, re-enable resumes with the held payload
    step(4'b0010, 4'b0000, 1'b1, 1'b0);
    saved       = cmd_v[0][1];
    for (int c = 0; c < 3; c++) step(4'b0000, 4'b0000, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    #1;
    check("s6_payload", 128'(out2), 128'(saved));
    check("s6_grant", 128'(grant2), 128'(2'b01));

    // random traffic
    for (int c = 0; c < 400; c++) begin
      step(4'($urandom), 4'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0));
    end
    for (int c = 0; c < 6; c++) step(4'b0000, 4'b0000, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
